// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the multi-lap stopwatch: FSM encoding,
// BCD time layout (mm:ss.cc) and the mixed-radix increment helper.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned N_DIGITS = 6;
  localparam int unsigned TIME_W   = DIGIT_W * N_DIGITS;
  localparam int unsigned DISP_W   = 4 * DIGIT_W;

  localparam logic [DIGIT_W-1:0] DEC_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] SEX_MAX = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  // cs0 occupies the least significant nibble.
  typedef struct packed {
    logic [DIGIT_W-1:0] m1;
    logic [DIGIT_W-1:0] m0;
    logic [DIGIT_W-1:0] s1;
    logic [DIGIT_W-1:0] s0;
    logic [DIGIT_W-1:0] cs1;
    logic [DIGIT_W-1:0] cs0;
  } bcd_time_t;

  localparam bcd_time_t ZERO_TIME = '0;
  localparam bcd_time_t MAX_TIME  = '{m1: 4'd5, m0: 4'd9, s1: 4'd5,
                                      s0: 4'd9, cs1: 4'd9, cs0: 4'd9};

  // Digit positions 3 (s1) and 5 (m1) count modulo 6, the rest modulo 10.
  function automatic logic [DIGIT_W-1:0] digit_max(input int unsigned pos);
    return (pos == 3 || pos == 5) ? SEX_MAX : DEC_MAX;
  endfunction

  function automatic bcd_time_t time_inc(input bcd_time_t t);
    logic [TIME_W-1:0] v;
    logic              carry;
    v     = t;
    carry = 1'b1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (v[i*DIGIT_W +: DIGIT_W] == digit_max(i)) begin
          v[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          v[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
          carry = 1'b0;
        end
      end
    end
    return bcd_time_t'(v);
  endfunction

endpackage

// File: rtl/sw_lap_buffer.sv
// Circular lap store: LAP_DEPTH BCD time records, saturating count with
// sticky overwrite flag, and read addressed by age (1 = newest).
module sw_lap_buffer
  import stopwatch_pkg::*;
#(
  parameter int unsigned LAP_DEPTH = 8,
  parameter int unsigned LAP_AW    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            clr,
  input  bcd_time_t       wr_data,
  input  logic [LAP_AW:0] rd_age,
  output bcd_time_t       rd_data_c,
  output logic [LAP_AW:0] lap_count,
  output logic            lap_ovf
);

  localparam int unsigned       CW       = LAP_AW + 1;
  localparam logic [LAP_AW-1:0] PTR_LAST = LAP_AW'(LAP_DEPTH - 1);
  localparam logic [LAP_AW:0]   CNT_FULL = CW'(LAP_DEPTH);

  bcd_time_t         mem_q [LAP_DEPTH];
  bcd_time_t         mem_d [LAP_DEPTH];
  logic [LAP_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LAP_AW:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [LAP_AW:0]   ptr_ext;
  logic [LAP_AW-1:0] rd_addr;

  // Write path: clear has priority; a write when full overwrites the oldest slot.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + LAP_AW'(1);
      if (count_q == CNT_FULL) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Age n lives n slots behind the write pointer, modulo the depth.
  always_comb begin
    ptr_ext = CW'(wr_ptr_q);
    if (ptr_ext >= rd_age) begin
      rd_addr = LAP_AW'(ptr_ext - rd_age);
    end else begin
      rd_addr = LAP_AW'(ptr_ext + CNT_FULL - rd_age);
    end
    rd_data_c = (rd_age == '0) ? ZERO_TIME : mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: ZERO_TIME};
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign lap_count = count_q;
  assign lap_ovf   = ovf_q;

endmodule

// File: rtl/multilap_stopwatch.sv
// Stopwatch core: 10 ms prescaler, BCD mm:ss.cc timer, run/pause/clear FSM,
// lap capture and review, and a registered 4-digit display selection.
module multilap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned LAP_DEPTH = 8,
  parameter int unsigned LAP_AW    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start,
  input  logic              btn_lap,
  input  logic              btn_next,
  input  logic              view_sel,
  input  logic              win_sel,
  output logic [DISP_W-1:0] disp_bcd,
  output logic              running,
  output logic [LAP_AW:0]   lap_count,
  output logic [LAP_AW:0]   lap_idx,
  output logic              lap_ovf,
  output logic              wrap
);

  localparam int unsigned      PRE_W    = $clog2(TICK_DIV);
  localparam int unsigned      IDX_W    = LAP_AW + 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  sw_state_e         state_q, state_d;
  bcd_time_t         time_q, time_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [LAP_AW:0]   lap_idx_q, lap_idx_d;
  logic              view_q;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic              running_q, running_d;
  logic              wrap_q, wrap_d;
  logic              tick_c, lap_wr_c, lap_clr_c;
  bcd_time_t         lap_rd_c, shown_c;

  assign tick_c = (state_q == ST_RUN) && (pre_q == PRE_LAST);

  // FSM, prescaler and time register; start wins over lap in the same cycle.
  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    pre_d     = pre_q;
    wrap_d    = 1'b0;
    lap_wr_c  = 1'b0;
    lap_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (btn_start) begin
          state_d = ST_PAUSE;
        end else if (btn_lap) begin
          lap_wr_c = 1'b1;
        end
        if (tick_c) begin
          pre_d  = '0;
          time_d = time_inc(time_q);
          wrap_d = (time_q == MAX_TIME);
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      ST_PAUSE: begin
        if (btn_start) begin
          state_d = ST_RUN;
        end else if (btn_lap) begin
          state_d   = ST_IDLE;
          time_d    = ZERO_TIME;
          pre_d     = '0;
          lap_clr_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RUN);
  end

  // Review index: newest on entry, btn_next walks older and wraps to newest.
  always_comb begin
    lap_idx_d = lap_idx_q;
    if (!view_sel) begin
      lap_idx_d = '0;
    end else if (!view_q) begin
      lap_idx_d = (lap_count == '0) ? '0 : IDX_W'(1);
    end else if (btn_next && (lap_count != '0)) begin
      lap_idx_d = (lap_idx_q >= lap_count) ? IDX_W'(1) : lap_idx_q + IDX_W'(1);
    end
    if (lap_clr_c) lap_idx_d = '0;
  end

  always_comb begin
    shown_c = view_sel ? lap_rd_c : time_q;
    disp_d  = win_sel ? {shown_c.m1, shown_c.m0, shown_c.s1, shown_c.s0}
                      : {shown_c.s1, shown_c.s0, shown_c.cs1, shown_c.cs0};
  end

  sw_lap_buffer #(
    .LAP_DEPTH (LAP_DEPTH),
    .LAP_AW    (LAP_AW)
  ) u_laps (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (lap_wr_c),
    .clr       (lap_clr_c),
    .wr_data   (time_q),
    .rd_age    (lap_idx_q),
    .rd_data_c (lap_rd_c),
    .lap_count (lap_count),
    .lap_ovf   (lap_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      time_q    <= ZERO_TIME;
      pre_q     <= '0;
      lap_idx_q <= '0;
      view_q    <= 1'b0;
      disp_q    <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      pre_q     <= pre_d;
      lap_idx_q <= lap_idx_d;
      view_q    <= view_sel;
      disp_q    <= disp_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  assign disp_bcd = disp_q;
  assign running  = running_q;
  assign lap_idx  = lap_idx_q;
  assign wrap     = wrap_q;

endmodule
